// File: rtl/quad_cmd_pkg.sv
// Shared definitions for the quadcopter command link: opcode encodings, the
// positive-acknowledge byte returned by the copter, and the state encoding of
// the remote-side command sender.
package quad_cmd_pkg;

  // Command opcodes carried in the first byte of every frame.
  typedef enum logic [7:0] {
    SET_PITCH  = 8'h02,
    SET_ROLL   = 8'h03,
    SET_YAW    = 8'h04,
    SET_THRST  = 8'h05,
    CALIBRATE  = 8'h06,
    EMER_LAND  = 8'h07,
    MOTORS_OFF = 8'h08
  } opcode_e;

  // Response byte the copter sends for an accepted command.
  localparam logic [7:0] POS_ACK = 8'hA5;

  // remote_cmd_send sequencing.
  typedef enum logic [2:0] {
    StIdle,
    StTxCmd,
    StTxHi,
    StTxLo,
    StWaitResp
  } send_state_e;

endpackage

// File: rtl/resp_tmo_tmr.sv
// Response timeout timer: clearable up-counter that stops at CYCLES-1.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear to zero (has priority over en)
//   en          count enable
//   full        high while the count equals CYCLES-1
module resp_tmo_tmr #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic full
);

  localparam int unsigned W = ($clog2(CYCLES) > 0) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] Last = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign full = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !full) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/remote_cmd_send.sv
// Remote-side command initiator. Latches an opcode and 16-bit payload, sends
// them as three bytes (cmd, data[15:8], data[7:0]) through the byte UART, then
// waits for the single response byte from the copter and reports it.
//
// Optional feature macro: RESP_TIMEOUT_EN
//   defined   - response timeout of TMO_CYCLES cycles, up to MAX_RETRY resends
//               of the latched frame, then a timeout pulse with resp = 8'h00.
//   undefined - WAIT_RESP waits indefinitely, timeout is tied low.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   snd_cmd, cmd, data  request pulse with opcode/payload (accepted in IDLE only)
//   busy                high while a command is in flight
//   resp, resp_rdy      response byte and its one-cycle valid pulse
//   pos_ack             registered (resp == 8'hA5)
//   timeout             one-cycle pulse when retries are exhausted
//   tx_data, trmt       byte to transmit and start-transmit pulse
//   tx_done             transmitter finished the current byte
//   rx_rdy, rx_data     receiver holds a byte
//   clr_rx_rdy          one-cycle pulse consuming the received byte
module remote_cmd_send
  import quad_cmd_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 1_000_000,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        busy,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        pos_ack,
  output logic        timeout,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy
);

  send_state_e state_q, state_d;

  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        trmt_q, trmt_d;
  logic        clr_rx_rdy_q, clr_rx_rdy_d;
  logic [7:0]  resp_q, resp_d;
  logic        pos_ack_q, pos_ack_d;
  logic        resp_rdy_q, resp_rdy_d;
  logic        in_tx;

`ifdef RESP_TIMEOUT_EN
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);

  logic [RetryW-1:0] retry_q, retry_d;
  logic              timeout_q, timeout_d;
  logic              tmo_full;
  logic              in_wait;

  assign in_wait = (state_q == StWaitResp);

  // Held clear outside WAIT_RESP, so every entry starts a fresh count.
  resp_tmo_tmr #(
    .CYCLES (TMO_CYCLES)
  ) u_resp_tmo_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!in_wait),
    .en    (in_wait),
    .full  (tmo_full)
  );

  assign timeout = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(TMO_CYCLES), 32'(MAX_RETRY)};
  assign timeout    = 1'b0;
`endif

  assign in_tx = (state_q == StTxCmd) || (state_q == StTxHi) || (state_q == StTxLo);

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    tx_data_d    = tx_data_q;
    trmt_d       = 1'b0;
    clr_rx_rdy_d = 1'b0;
    resp_d       = resp_q;
    pos_ack_d    = pos_ack_q;
    resp_rdy_d   = 1'b0;
`ifdef RESP_TIMEOUT_EN
    retry_d      = retry_q;
    timeout_d    = 1'b0;
`endif

    // Stale/echo bytes during transmission are discarded. A clear already in
    // flight means the receiver has not dropped rx_rdy yet; do not clear twice.
    if (in_tx && rx_rdy && !clr_rx_rdy_q) begin
      clr_rx_rdy_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (snd_cmd) begin
          cmd_d     = cmd;
          data_d    = data;
          tx_data_d = cmd;
          trmt_d    = 1'b1;
          state_d   = StTxCmd;
`ifdef RESP_TIMEOUT_EN
          retry_d   = '0;
`endif
        end
      end
      StTxCmd: begin
        if (tx_done) begin
          tx_data_d = data_q[15:8];
          trmt_d    = 1'b1;
          state_d   = StTxHi;
        end
      end
      StTxHi: begin
        if (tx_done) begin
          tx_data_d = data_q[7:0];
          trmt_d    = 1'b1;
          state_d   = StTxLo;
        end
      end
      StTxLo: begin
        if (tx_done) begin
          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        // A byte whose clear is still in flight was a stale one from TX_LO.
        if (rx_rdy && !clr_rx_rdy_q) begin
          resp_d       = rx_data;
          pos_ack_d    = (rx_data == POS_ACK);
          resp_rdy_d   = 1'b1;
          clr_rx_rdy_d = 1'b1;
          state_d      = StIdle;
        end
`ifdef RESP_TIMEOUT_EN
        else if (tmo_full) begin
          if (retry_q < MaxRetry) begin
            retry_d   = retry_q + RetryW'(1);
            tx_data_d = cmd_q;
            trmt_d    = 1'b1;
            state_d   = StTxCmd;
          end else begin
            resp_d    = 8'h00;
            pos_ack_d = 1'b0;
            timeout_d = 1'b1;
            state_d   = StIdle;
          end
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cmd_q        <= 8'h00;
      data_q       <= 16'h0000;
      tx_data_q    <= 8'h00;
      trmt_q       <= 1'b0;
      clr_rx_rdy_q <= 1'b0;
      resp_q       <= 8'h00;
      pos_ack_q    <= 1'b0;
      resp_rdy_q   <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      retry_q      <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      tx_data_q    <= tx_data_d;
      trmt_q       <= trmt_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
      resp_q       <= resp_d;
      pos_ack_q    <= pos_ack_d;
      resp_rdy_q   <= resp_rdy_d;
`ifdef RESP_TIMEOUT_EN
      retry_q      <= retry_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign busy       = (state_q != StIdle);
  assign resp       = resp_q;
  assign pos_ack    = pos_ack_q;
  assign resp_rdy   = resp_rdy_q;
  assign tx_data    = tx_data_q;
  assign trmt       = trmt_q;
  assign clr_rx_rdy = clr_rx_rdy_q;

endmodule

// File: tb/tb_remote_cmd_send.sv
module tb_remote_cmd_send;

  localparam int unsigned TMO    = 64;
  localparam int unsigned RETRY  = 2;
  localparam int unsigned BYTE_T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        busy;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        pos_ack;
  logic        timeout;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;

  logic        rx_set;
  logic [7:0]  rx_set_data;

  int total = 0;
  int bad = 0;
  int trmt_cnt = 0;
  int done_cnt = 0;
  int clr_cnt = 0;
  int done_target = 0;
  int tx_cnt = 0;
  int tx_pos = 0;
  bit prev_done = 1'b0;
  bit tmo_allowed = 1'b0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_resp[$];

  always #5 clk = ~clk;

  remote_cmd_send #(
    .TMO_CYCLES (TMO),
    .MAX_RETRY  (RETRY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .snd_cmd    (snd_cmd),
    .cmd        (cmd),
    .data       (data),
    .busy       (busy),
    .resp       (resp),
    .resp_rdy   (resp_rdy),
    .pos_ack    (pos_ack),
    .timeout    (timeout),
    .tx_data    (tx_data),
    .trmt       (trmt),
    .tx_done    (tx_done),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART transmitter model: tx_done one byte time after each trmt.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt  <= 0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt) begin
        tx_cnt <= BYTE_T;
      end else if (tx_cnt == 1) begin
        tx_done  <= 1'b1;
        tx_cnt   <= 0;
        done_cnt <= done_cnt + 1;
      end else if (tx_cnt != 0) begin
        tx_cnt <= tx_cnt - 1;
      end
    end
  end

  // UART receiver model: rx_rdy holds until clr_rx_rdy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_rdy  <= 1'b0;
      rx_data <= 8'h00;
    end else if (clr_rx_rdy) begin
      rx_rdy <= 1'b0;
    end else if (rx_set) begin
      rx_rdy  <= 1'b1;
      rx_data <= rx_set_data;
    end
  end

  always @(posedge clk) begin
    if (trmt) trmt_cnt <= trmt_cnt + 1;
    if (clr_rx_rdy) clr_cnt <= clr_cnt + 1;
  end

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      exp_tx.delete();
      tx_pos    = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done && tx_pos != 0) chk("trmt_cycle_after_tx_done", trmt, 1);
      prev_done = tx_done;
      if (trmt) begin
        chk("trmt_expected", 32'(exp_tx.size() > 0), 1);
        if (exp_tx.size() > 0) begin
          e = exp_tx.pop_front();
          chk("tx_data", tx_data, e);
        end
        tx_pos = (tx_pos == 2) ? 0 : tx_pos + 1;
      end
      if (resp_rdy) begin
        chk("resp_rdy_expected", 32'(exp_resp.size() > 0), 1);
        if (exp_resp.size() > 0) begin
          e = exp_resp.pop_front();
          chk("resp", resp, e);
          chk("pos_ack", pos_ack, (e == 8'hA5));
        end
        chk("busy_at_resp", busy, 0);
        chk("clr_at_resp", clr_rx_rdy, 1);
      end
      if (timeout) begin
        chk("timeout_expected", tmo_allowed, 1);
        chk("resp_at_timeout", resp, 8'h00);
        chk("pos_ack_at_timeout", pos_ack, 0);
        chk("busy_at_timeout", busy, 0);
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_resp", resp, 8'h00);
    chk("rst_pos_ack", pos_ack, 0);
    chk("rst_resp_rdy", resp_rdy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_trmt", trmt, 0);
    chk("rst_clr_rx_rdy", clr_rx_rdy, 0);
  endtask

  // Call at a falling edge; returns at the falling edge after acceptance.
  task automatic send_cmd(input logic [7:0] c, input logic [15:0] d);
    exp_tx.push_back(c);
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[7:0]);
    done_target = done_cnt + 3;
    snd_cmd = 1'b1;
    cmd     = c;
    data    = d;
    @(negedge clk);
    snd_cmd = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_trmt", trmt, 1);
    chk("accept_tx_data", tx_data, c);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_done_in_time", 32'(done_cnt >= target), 1);
  endtask

  task automatic wait_trmt(input int target);
    int n = 0;
    while (trmt_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("trmt_in_time", 32'(trmt_cnt >= target), 1);
  endtask

  // Returns at the falling edge of the resp_rdy cycle.
  task automatic respond(input logic [7:0] rb);
    wait_done(done_target);
    @(negedge clk);
    exp_resp.push_back(rb);
    rx_set      = 1'b1;
    rx_set_data = rb;
    @(negedge clk);
    rx_set = 1'b0;
    chk("resp_rdy_not_early", resp_rdy, 0);
    @(negedge clk);
    chk("resp_rdy_latency", resp_rdy, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int c0;
    int n;
    snd_cmd     = 1'b0;
    cmd         = 8'h00;
    data        = 16'h0000;
    rx_set      = 1'b0;
    rx_set_data = 8'h00;

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame; a second request while busy must be ignored.
    t0 = trmt_cnt;
    send_cmd(8'h02, 16'h1234);
    wait_trmt(t0 + 2);
    snd_cmd = 1'b1;
    cmd     = 8'h05;
    data    = 16'hFFFF;
    @(negedge clk);
    snd_cmd = 1'b0;
    respond(8'hA5);
    repeat (20) @(negedge clk);
    chk("frame1_trmt_count", trmt_cnt - t0, 3);
    chk("idle_busy", busy, 0);

    // Stale byte during TX_HI is cleared and not reported.
    t0 = trmt_cnt;
    send_cmd(8'h03, 16'hABCD);
    wait_trmt(t0 + 2);
    c0 = clr_cnt;
    rx_set      = 1'b1;
    rx_set_data = 8'h77;
    @(negedge clk);
    rx_set = 1'b0;
    repeat (3) @(negedge clk);
    chk("stale_clr_count", clr_cnt - c0, 1);
    chk("stale_still_busy", busy, 1);
    respond(8'hA5);

    // Earliest next acceptance right in the resp_rdy cycle; negative response.
    send_cmd(8'h04, 16'h0001);
    respond(8'h5A);
    @(negedge clk);

`ifdef RESP_TIMEOUT_EN
    // No response: frame sent 1 + RETRY times, then timeout.
    t0 = trmt_cnt;
    send_cmd(8'h08, 16'hBEEF);
    for (int r = 0; r < int'(RETRY); r++) begin
      exp_tx.push_back(8'h08);
      exp_tx.push_back(8'hBE);
      exp_tx.push_back(8'hEF);
    end
    tmo_allowed = 1'b1;
    wait_done(done_target + 3 * int'(RETRY));
    n = 0;
    while (!timeout && n < int'(TMO) * 4) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_gap", n, TMO + 1);
    chk("timeout_pulse", timeout, 1);
    chk("timeout_trmt_count", trmt_cnt - t0, 3 * (RETRY + 1));
    @(negedge clk);
    tmo_allowed = 1'b0;
    chk("timeout_one_cycle", timeout, 0);
    chk("busy_after_timeout", busy, 0);
`else
    // No timeout logic: keeps waiting well past TMO cycles.
    t0 = trmt_cnt;
    send_cmd(8'h08, 16'hBEEF);
    repeat (3 * TMO) @(negedge clk);
    chk("no_tmo_still_busy", busy, 1);
    chk("no_tmo_trmt_count", trmt_cnt - t0, 3);
    respond(8'hA5);
    @(negedge clk);
`endif

    // Reset mid-frame after the second byte starts.
    t0 = trmt_cnt;
    send_cmd(8'h06, 16'h5555);
    wait_trmt(t0 + 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    t0 = trmt_cnt;
    repeat (5) @(negedge clk);
    chk("quiet_after_reset", trmt_cnt - t0, 0);
    chk("idle_after_reset", busy, 0);

    t0 = trmt_cnt;
    send_cmd(8'h07, 16'h0102);
    respond(8'hA5);
    @(negedge clk);
    chk("post_reset_trmt_count", trmt_cnt - t0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
